// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core operand loader.
// Optional feature macro: TENSOR_CORE_OPERAND_LOADER_WEIGHT_REUSE_EN (no effect on this package).
package tensor_core_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int MATRIX_DIM   = 4;
  localparam int MATRIX_ELEMS = MATRIX_DIM * MATRIX_DIM;
  localparam int INDEX_W      = $clog2(MATRIX_ELEMS);

  typedef logic [DATA_WIDTH-1:0] elem_t;

  // Packed so a matrix travels as a single port; m[row][col].
  typedef elem_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

  typedef logic [INDEX_W-1:0] index_t;

  localparam index_t LAST_INDEX = index_t'(MATRIX_ELEMS - 1);

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    KICK      = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

  // Streaming states are the only ones that accept elements.
  function automatic logic is_load_state(input loader_state_t s);
    return (s == LOAD_A) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/tensor_core_operand_loader_operand_matrix_buffer.sv
// operand_matrix_buffer: 16-entry write-indexed register array holding one
// 4x4 operand matrix. Element k lands at row k/4, column k%4.
// Optional feature macro: TENSOR_CORE_OPERAND_LOADER_WEIGHT_REUSE_EN (no effect here).
module operand_matrix_buffer #(
  parameter int DATA_WIDTH = tensor_core_pkg::DATA_WIDTH
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  input  logic                          write_en,
  input  tensor_core_pkg::index_t       index,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic [tensor_core_pkg::MATRIX_DIM-1:0][tensor_core_pkg::MATRIX_DIM-1:0][DATA_WIDTH-1:0] matrix
);
  import tensor_core_pkg::*;

  localparam int HALF_W = INDEX_W / 2;

  logic [HALF_W-1:0] row;
  logic [HALF_W-1:0] col;

  assign row = index[INDEX_W-1:HALF_W];
  assign col = index[HALF_W-1:0];

  // Entries change only on a write; unwritten slots keep their old contents.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      matrix <= '0;
    end else if (write_en) begin
      matrix[row][col] <= data;
    end
  end

endmodule

// File: rtl/tensor_core_operand_loader.sv
// tensor_core_operand_loader: collects a row-major byte stream into operands
// A and B, strobes the tensor core's write enable, and holds both operands
// until the core reports completion (or the wait times out).
// Optional feature macro: TENSOR_CORE_OPERAND_LOADER_WEIGHT_REUSE_EN adds
// reuse_b_in; when sampled high on the first element of a frame, LOAD_B is
// skipped and the previous B operand is reused.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// LOAD_A    | accepting elements 0..15 into operand A
// LOAD_B    | accepting elements 0..15 into operand B
// KICK      | write enable high for KICK_CYCLES cycles
// WAIT_DONE | operands frozen; waiting for done (first cycle ignores done)
module tensor_core_operand_loader #(
  parameter int DATA_WIDTH   = tensor_core_pkg::DATA_WIDTH,
  parameter int KICK_CYCLES  = 1,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [DATA_WIDTH-1:0] load_data_in,
  input  logic                  load_valid_in,
  output logic                  load_ready_out,
  output logic [tensor_core_pkg::MATRIX_DIM-1:0][tensor_core_pkg::MATRIX_DIM-1:0][DATA_WIDTH-1:0] tensor_core_input1,
  output logic [tensor_core_pkg::MATRIX_DIM-1:0][tensor_core_pkg::MATRIX_DIM-1:0][DATA_WIDTH-1:0] tensor_core_input2,
  output logic                  tensor_core_register_file_write_enable,
  input  logic                  is_done_with_calculation,
  output logic                  busy_out,
  output logic                  timeout_error_out
`ifdef TENSOR_CORE_OPERAND_LOADER_WEIGHT_REUSE_EN
  ,
  input  logic                  reuse_b_in
`endif
);
  import tensor_core_pkg::*;

  localparam int KICK_W = 3;
  localparam logic [KICK_W-1:0] KICK_LOAD = KICK_W'(KICK_CYCLES - 1);

  localparam int WAIT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic TIMEOUT_EN = (DONE_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (DONE_TIMEOUT > 0) ? WAIT_W'(DONE_TIMEOUT - 1) : '0;

  loader_state_t     state_q, state_d;
  index_t            index_q, index_d;
  logic [KICK_W-1:0] kick_cnt_q, kick_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              first_wait_q, first_wait_d;
  logic              err_q, err_d;
  logic              ready_q;
  logic              we_q;
  logic              xfer;
  logic              write_a;
  logic              write_b;
  logic              skip_b;

  assign xfer = load_valid_in & ready_q;

`ifdef TENSOR_CORE_OPERAND_LOADER_WEIGHT_REUSE_EN
  logic reuse_q;

  // Capture the reuse request alongside the first element of each frame.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      reuse_q <= 1'b0;
    end else if (xfer && (state_q == LOAD_A) && (index_q == '0)) begin
      reuse_q <= reuse_b_in;
    end
  end

  assign skip_b = reuse_q;
`else
  assign skip_b = 1'b0;
`endif

  // Next-state logic; counters are down-counters loaded on state entry.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    kick_cnt_d   = kick_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    first_wait_d = 1'b0;
    err_d        = err_q;
    write_a      = 1'b0;
    write_b      = 1'b0;

    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          write_a = 1'b1;
          if (index_q == LAST_INDEX) begin
            index_d = '0;
            if (skip_b) begin
              state_d    = KICK;
              kick_cnt_d = KICK_LOAD;
              err_d      = 1'b0;
            end else begin
              state_d = LOAD_B;
            end
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      LOAD_B: begin
        if (xfer) begin
          write_b = 1'b1;
          if (index_q == LAST_INDEX) begin
            index_d    = '0;
            state_d    = KICK;
            kick_cnt_d = KICK_LOAD;
            err_d      = 1'b0;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      KICK: begin
        if (kick_cnt_q == '0) begin
          state_d      = WAIT_DONE;
          wait_cnt_d   = WAIT_LOAD;
          first_wait_d = 1'b1;
        end else begin
          kick_cnt_d = kick_cnt_q - 1'b1;
        end
      end

      WAIT_DONE: begin
        // A done left over from the previous job may still be high on the
        // first cycle, so it only counts from the second cycle on.
        if (!first_wait_q && is_done_with_calculation) begin
          state_d = LOAD_A;
        end else if (TIMEOUT_EN && (wait_cnt_q == '0)) begin
          state_d = LOAD_A;
          err_d   = 1'b1;
        end else if (TIMEOUT_EN) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = LOAD_A;
        index_d = '0;
      end
    endcase
  end

  // State, counters and registered strobes; ready/we decode the next state.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= LOAD_A;
      index_q      <= '0;
      kick_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      first_wait_q <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      kick_cnt_q   <= kick_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      first_wait_q <= first_wait_d;
      err_q        <= err_d;
      ready_q      <= is_load_state(state_d);
      we_q         <= (state_d == KICK);
    end
  end

  assign load_ready_out                         = ready_q;
  assign tensor_core_register_file_write_enable = we_q;
  assign timeout_error_out                      = err_q;
  assign busy_out = !((state_q == LOAD_A) && (index_q == '0));

  operand_matrix_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_a (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .write_en (write_a),
    .index    (index_q),
    .data     (load_data_in),
    .matrix   (tensor_core_input1)
  );

  operand_matrix_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_b (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .write_en (write_b),
    .index    (index_q),
    .data     (load_data_in),
    .matrix   (tensor_core_input2)
  );

endmodule
